// File: rtl/mipi_csi_rx_packet_decoder_8b4lane.sv
// mipi_csi_rx_packet_decoder_8b4lane
//
// Purpose: parses CSI-2 packet headers from lane-aligned 32-bit words (one byte
// per lane) and forwards long-packet payload words to the raw depacker. The
// header and CRC are stripped, and bytes past the word count are zeroed. Short
// packets produce frame start / frame end pulses. A long packet whose valid
// drops early is flagged with a one-cycle error pulse.
//
// Ports:
//   clk_i           byte clock
//   reset_n_i       asynchronous active-low reset
//   data_valid_i    aligner word valid, high for a whole packet
//   data_i          lane bytes, lane0 = [7:0] ... lane3 = [31:24]
//   output_valid_o  payload word valid
//   output_o        payload word, same byte order as data_i
//   packet_type_o   0 none, 1 RAW8, 2 RAW12, 3 RAW10, 4 RAW14, 5 RAW16
//   frame_start_o   one-cycle pulse on short packet DT 0x00
//   frame_end_o     one-cycle pulse on short packet DT 0x01
//   packet_error_o  one-cycle pulse on truncated long packet
module mipi_csi_rx_packet_decoder_8b4lane #(
   parameter logic [1:0] VC_FILTER = 2'd0
) (
   input  logic        clk_i,
   input  logic        reset_n_i,
   input  logic        data_valid_i,
   input  logic [31:0] data_i,
   output logic        output_valid_o,
   output logic [31:0] output_o,
   output logic [2:0]  packet_type_o,
   output logic        frame_start_o,
   output logic        frame_end_o,
   output logic        packet_error_o
);

   typedef enum logic [1:0] {
      StIdle,
      StPayload,
      StWaitEnd
   } state_e;

   state_e      state_q;
   logic [16:0] remaining_q;

   logic [1:0]  hdr_vc;
   logic [5:0]  hdr_dt;
   logic [15:0] hdr_wc;
   logic [2:0]  hdr_type;
   logic [3:0]  byte_keep;
   logic [31:0] masked_data;

   always_comb begin
      hdr_vc = data_i[7:6];
      hdr_dt = data_i[5:0];
      hdr_wc = data_i[23:8];
      hdr_type = 3'd0;
      case (hdr_dt)
         6'h2A:   hdr_type = 3'd1;
         6'h2C:   hdr_type = 3'd2;
         6'h2B:   hdr_type = 3'd3;
         6'h2D:   hdr_type = 3'd4;
         6'h2E:   hdr_type = 3'd5;
         default: hdr_type = 3'd0;
      endcase
   end

   // Lane i carries payload only while more than i bytes are still owed; this
   // drops CRC and padding that share the last payload word.
   always_comb begin
      byte_keep[0] = (remaining_q != 17'd0);
      byte_keep[1] = (remaining_q > 17'd1);
      byte_keep[2] = (remaining_q > 17'd2);
      byte_keep[3] = (remaining_q > 17'd3);
      masked_data = '0;
      for (int i = 0; i < 4; i++) begin
         masked_data[8*i +: 8] = byte_keep[i] ? data_i[8*i +: 8] : 8'h00;
      end
   end

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         state_q        <= StIdle;
         remaining_q    <= '0;
         output_valid_o <= 1'b0;
         output_o       <= '0;
         packet_type_o  <= '0;
         frame_start_o  <= 1'b0;
         frame_end_o    <= 1'b0;
         packet_error_o <= 1'b0;
      end else begin
         output_valid_o <= 1'b0;
         frame_start_o  <= 1'b0;
         frame_end_o    <= 1'b0;
         packet_error_o <= 1'b0;
         case (state_q)
            StIdle: begin
               if (data_valid_i) begin
                  state_q <= StWaitEnd;
                  if (hdr_vc == VC_FILTER) begin
                     if (hdr_dt <= 6'h0F) begin
                        frame_start_o <= (hdr_dt == 6'h00);
                        frame_end_o   <= (hdr_dt == 6'h01);
                     end else if (hdr_type != 3'd0) begin
                        packet_type_o <= hdr_type;
                        if (hdr_wc != 16'd0) begin
                           remaining_q <= {1'b0, hdr_wc};
                           state_q     <= StPayload;
                        end
                     end
                  end
               end
            end
            StPayload: begin
               if (data_valid_i) begin
                  output_valid_o <= 1'b1;
                  output_o       <= masked_data;
                  if (remaining_q <= 17'd4) begin
                     remaining_q <= '0;
                     state_q     <= StWaitEnd;
                  end else begin
                     remaining_q <= remaining_q - 17'd4;
                  end
               end else begin
                  packet_error_o <= 1'b1;
                  remaining_q    <= '0;
                  state_q        <= StIdle;
               end
            end
            StWaitEnd: begin
               if (!data_valid_i) begin
                  state_q <= StIdle;
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

endmodule

// File: tb/tb_mipi_csi_rx_packet_decoder_8b4lane.sv
module tb_mipi_csi_rx_packet_decoder_8b4lane;

   localparam logic [1:0] VC = 2'd0;

   logic        clk;
   logic        reset_n;
   logic        data_valid;
   logic [31:0] data;
   logic        output_valid;
   logic [31:0] output_word;
   logic [2:0]  packet_type;
   logic        frame_start;
   logic        frame_end;
   logic        packet_error;

   mipi_csi_rx_packet_decoder_8b4lane #(
      .VC_FILTER (VC)
   ) dut (
      .clk_i          (clk),
      .reset_n_i      (reset_n),
      .data_valid_i   (data_valid),
      .data_i         (data),
      .output_valid_o (output_valid),
      .output_o       (output_word),
      .packet_type_o  (packet_type),
      .frame_start_o  (frame_start),
      .frame_end_o    (frame_end),
      .packet_error_o (packet_error)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int total = 0;
   int bad = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Observed output stream, collected away from the clock edge.
   logic [34:0] act_q[$];
   int          act_fs;
   int          act_fe;
   int          act_err;

   always @(negedge clk) begin
      if (reset_n) begin
         if (output_valid) act_q.push_back({packet_type, output_word});
         if (frame_start) act_fs++;
         if (frame_end) act_fe++;
         if (packet_error) act_err++;
      end
   end

   // Reference model: one packet (header + driven words) in, expected events out.
   logic [31:0] stim_q[$];
   logic [31:0] exp_q[$];
   int          exp_fs;
   int          exp_fe;
   int          exp_err;
   logic [2:0]  model_type = 3'd0;

   function automatic logic [2:0] type_of(input logic [5:0] dt);
      case (dt)
         6'h2A:   return 3'd1;
         6'h2C:   return 3'd2;
         6'h2B:   return 3'd3;
         6'h2D:   return 3'd4;
         6'h2E:   return 3'd5;
         default: return 3'd0;
      endcase
   endfunction

   task automatic model_packet();
      logic [31:0] hdr;
      logic [31:0] w;
      logic [5:0]  dt;
      logic [2:0]  t;
      int          wc;
      int          nwords;
      int          avail;
      int          left;
      exp_q.delete();
      exp_fs = 0;
      exp_fe = 0;
      exp_err = 0;
      hdr = stim_q[0];
      dt = hdr[5:0];
      wc = int'(hdr[23:8]);
      if (hdr[7:6] != VC) return;
      if (dt <= 6'h0F) begin
         exp_fs = (dt == 6'h00) ? 1 : 0;
         exp_fe = (dt == 6'h01) ? 1 : 0;
         return;
      end
      t = type_of(dt);
      if (t == 3'd0) return;
      model_type = t;
      nwords = (wc + 3) / 4;
      avail = stim_q.size() - 1;
      for (int i = 0; i < nwords && i < avail; i++) begin
         w = stim_q[i+1];
         left = wc - 4 * i;
         for (int b = 0; b < 4; b++) begin
            if (b >= left) w[8*b +: 8] = 8'h00;
         end
         exp_q.push_back(w);
      end
      exp_err = (avail < nwords) ? 1 : 0;
   endtask

   task automatic run_packet(input string name);
      act_q.delete();
      act_fs = 0;
      act_fe = 0;
      act_err = 0;
      foreach (stim_q[i]) begin
         @(posedge clk);
         #1;
         data_valid = 1'b1;
         data = stim_q[i];
      end
      @(posedge clk);
      #1;
      data_valid = 1'b0;
      data = $urandom;
      repeat (4) @(posedge clk);
      #1;
      model_packet();
      check({name, ".nwords"}, 64'(act_q.size()), 64'(exp_q.size()));
      for (int i = 0; i < act_q.size() && i < exp_q.size(); i++) begin
         check({name, ".word"}, 64'(act_q[i][31:0]), 64'(exp_q[i]));
         check({name, ".word_type"}, 64'(act_q[i][34:32]), 64'(model_type));
      end
      check({name, ".fs"}, 64'(act_fs), 64'(exp_fs));
      check({name, ".fe"}, 64'(act_fe), 64'(exp_fe));
      check({name, ".err"}, 64'(act_err), 64'(exp_err));
      check({name, ".type"}, 64'(packet_type), 64'(model_type));
   endtask

   task automatic check_outputs_zero(input string name);
      check({name, ".valid"}, 64'(output_valid), 64'd0);
      check({name, ".out"}, 64'(output_word), 64'd0);
      check({name, ".type"}, 64'(packet_type), 64'd0);
      check({name, ".fs"}, 64'(frame_start), 64'd0);
      check({name, ".fe"}, 64'(frame_end), 64'd0);
      check({name, ".err"}, 64'(packet_error), 64'd0);
   endtask

   logic [5:0] dt_table[10] = '{6'h00, 6'h01, 6'h05, 6'h2A, 6'h2B,
                                6'h2C, 6'h2D, 6'h2E, 6'h12, 6'h30};

   initial begin
      reset_n = 1'b0;
      data_valid = 1'b0;
      data = '0;
      @(posedge clk);
      #1;
      check_outputs_zero("reset");
      @(negedge clk);
      reset_n = 1'b1;

      // RAW10 line with CRC in the upper bytes of the last word
      stim_q = '{32'h00000A2B, 32'h04030201, 32'h08070605, 32'hCCDD0A09};
      run_packet("raw10");
      check("raw10.last", 64'(act_q.size() == 3 ? act_q[2][31:0] : 32'hDEAD),
            64'h00000A09);

      // Frame markers
      stim_q = '{32'h00010000};
      run_packet("fs");
      stim_q = '{32'h00010001};
      run_packet("fe");

      // Foreign virtual channel is dropped, type keeps its previous value
      stim_q = '{32'h0008406B, 32'h11111111, 32'h22222222, 32'h33333333};
      run_packet("vc");

      // Truncated RAW8, then a clean packet
      stim_q = '{32'h0000102A, 32'hA1A2A3A4, 32'hB1B2B3B4};
      run_packet("trunc");
      stim_q = '{32'h0000052C, 32'h55667788, 32'hEEFF0099};
      run_packet("after_trunc");

      // Zero-length supported and unsupported long DT
      stim_q = '{32'h0000002A};
      run_packet("zero_len");
      stim_q = '{32'h00000412, 32'h12345678, 32'h0000BEEF};
      run_packet("unsup");

      // Randomized packets
      for (int n = 0; n < 40; n++) begin
         logic [5:0]  dt;
         logic [1:0]  vc;
         logic [15:0] wc;
         int          nw;
         dt = dt_table[$urandom_range(0, 9)];
         vc = ($urandom_range(0, 5) == 0) ? 2'($urandom_range(1, 3)) : VC;
         wc = 16'($urandom_range(0, 40));
         stim_q.delete();
         stim_q.push_back({8'($urandom), wc, vc, dt});
         if (dt <= 6'h0F) begin
            nw = $urandom_range(0, 1);
         end else begin
            nw = (int'(wc) + 2 + 3) / 4 + $urandom_range(0, 1);
            if ($urandom_range(0, 5) == 0 && wc != 16'd0)
               nw = $urandom_range(0, (int'(wc) + 3) / 4 - 1);
         end
         for (int i = 0; i < nw; i++) stim_q.push_back($urandom);
         run_packet("rand");
      end

      // Maximum word count
      stim_q.delete();
      stim_q.push_back(32'h00FFFF2E);
      for (int i = 0; i < 16385; i++) stim_q.push_back($urandom);
      run_packet("wc_max");

      // Asynchronous reset in the middle of a payload
      stim_q = '{32'h0000102B, 32'h01010101, 32'h02020202};
      foreach (stim_q[i]) begin
         @(posedge clk);
         #1;
         data_valid = 1'b1;
         data = stim_q[i];
      end
      @(posedge clk);
      #3;
      check("mid_reset.valid_before", 64'(output_valid), 64'd1);
      reset_n = 1'b0;
      #1;
      check_outputs_zero("mid_reset");
      data_valid = 1'b0;
      model_type = 3'd0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset_n = 1'b1;
      stim_q = '{32'h00000A2B, 32'h04030201, 32'h08070605, 32'hCCDD0A09};
      run_packet("post_reset");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
